// File: rtl/pattern_multi.sv
// pattern_multi: CHANNELS independent off/on blink engines with repeat,
// infinite-repeat (reps=0), abort, broadcast start and done pulse.
// Ports: hwclk, rst_n (async low), on_time/off_time/reps (packed per
// channel), start, start_all, abort -> bright, busy, done (registered).
// Optional PATTERN_PWM_EN adds input duty (CHANNELS*DUTY_W) and a shared
// free-running pwm_cnt; bright in ON becomes pwm_cnt < latched duty.
module pattern_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int REP_W    = 8,
  parameter int DUTY_W   = 4
) (
  input  logic                      hwclk,
  input  logic                      rst_n,
  input  logic [CHANNELS*CNT_W-1:0] on_time,
  input  logic [CHANNELS*CNT_W-1:0] off_time,
  input  logic [CHANNELS*REP_W-1:0] reps,
  input  logic [CHANNELS-1:0]       start,
  input  logic                      start_all,
  input  logic [CHANNELS-1:0]       abort,
  output logic [CHANNELS-1:0]       bright,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
`ifdef PATTERN_PWM_EN
  ,
  input  logic [CHANNELS*DUTY_W-1:0] duty
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OFF  = 2'd1,
    S_ON   = 2'd2
  } st_t;

`ifdef PATTERN_PWM_EN
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] pwm_nxt;

  assign pwm_nxt = pwm_cnt + DUTY_W'(1);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_nxt;
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    st_t              st, st_n;
    logic [CNT_W-1:0] on_s, on_n;
    logic [CNT_W-1:0] off_s, off_n;
    logic [CNT_W-1:0] ph, ph_n;
    logic [REP_W-1:0] rp_s, rp_n;
    logic [REP_W-1:0] rc, rc_n;
    logic             br_q, br_n;
    logic             bs_q, bs_n;
    logic             dn_q, dn_n;
    logic             go, last_off, last_on, rep_end, fin;
    logic [CNT_W-1:0] on_in, off_in;
`ifdef PATTERN_PWM_EN
    logic [DUTY_W-1:0] dt_s, dt_n;
`endif

    assign on_in  = on_time[c*CNT_W +: CNT_W];
    assign off_in = off_time[c*CNT_W +: CNT_W];
    assign go     = start[c] | start_all;

    // Zero off_time still costs one OFF cycle when on_time is zero too.
    assign last_off = (off_s == '0) || (ph == off_s - CNT_W'(1));
    assign last_on  = (ph == on_s - CNT_W'(1));
    assign rep_end  = (st == S_OFF && last_off && on_s == '0)
                    || (st == S_ON && last_on);
    assign fin      = (rp_s != '0) && (rc == rp_s - REP_W'(1));

    always_comb begin
      st_n  = st;
      on_n  = on_s;
      off_n = off_s;
      rp_n  = rp_s;
      rc_n  = rc;
      ph_n  = ph + CNT_W'(1);
      dn_n  = 1'b0;
`ifdef PATTERN_PWM_EN
      dt_n  = dt_s;
`endif
      unique case (st)
        S_IDLE: begin
          ph_n = ph;
          if (go && !abort[c]) begin
            on_n  = on_in;
            off_n = off_in;
            rp_n  = reps[c*REP_W +: REP_W];
            rc_n  = '0;
            ph_n  = '0;
`ifdef PATTERN_PWM_EN
            dt_n  = duty[c*DUTY_W +: DUTY_W];
`endif
            if (off_in == '0 && on_in != '0) st_n = S_ON;
            else                            st_n = S_OFF;
          end
        end
        S_OFF, S_ON: begin
          if (abort[c]) begin
            st_n = S_IDLE;
            ph_n = '0;
          end else if (rep_end) begin
            ph_n = '0;
            if (fin) begin
              st_n = S_IDLE;
              dn_n = 1'b1;
            end else begin
              // reps=0 runs forever: hold the rep counter.
              if (rp_s != '0) rc_n = rc + REP_W'(1);
              if (off_s == '0 && on_s != '0) st_n = S_ON;
              else                          st_n = S_OFF;
            end
          end else if (st == S_OFF && last_off) begin
            st_n = S_ON;
            ph_n = '0;
          end
        end
        default: begin
          st_n = S_IDLE;
          ph_n = '0;
        end
      endcase
      bs_n = (st_n != S_IDLE);
`ifdef PATTERN_PWM_EN
      // Registered bright must match the pwm_cnt value of the next cycle.
      br_n = (st_n == S_ON) && (pwm_nxt < dt_n);
`else
      br_n = (st_n == S_ON);
`endif
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= S_IDLE;
        on_s  <= '0;
        off_s <= '0;
        rp_s  <= '0;
        rc    <= '0;
        ph    <= '0;
        br_q  <= 1'b0;
        bs_q  <= 1'b0;
        dn_q  <= 1'b0;
      end else begin
        st    <= st_n;
        on_s  <= on_n;
        off_s <= off_n;
        rp_s  <= rp_n;
        rc    <= rc_n;
        ph    <= ph_n;
        br_q  <= br_n;
        bs_q  <= bs_n;
        dn_q  <= dn_n;
      end
    end

`ifdef PATTERN_PWM_EN
    always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) dt_s <= '0;
      else        dt_s <= dt_n;
    end
`endif

    assign bright[c] = br_q;
    assign busy[c]   = bs_q;
    assign done[c]   = dn_q;
  end

endmodule

// File: tb/tb_pattern_multi.sv
// tb_pattern_multi: directed checks of pattern_multi (default build).
// Drives on negedge, samples on negedge after each posedge.
module tb_pattern_multi;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int RW = 8;

  logic             hwclk = 1'b0;
  logic             rst_n;
  logic [CH*CW-1:0] on_time, off_time;
  logic [CH*RW-1:0] reps;
  logic [CH-1:0]    start, abort;
  logic             start_all;
  logic [CH-1:0]    bright, busy, done;

  int n_chk = 0;
  int n_err = 0;

  pattern_multi #(
    .CHANNELS(CH), .CNT_W(CW), .REP_W(RW), .DUTY_W(4)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n),
    .on_time(on_time), .off_time(off_time), .reps(reps),
    .start(start), .start_all(start_all), .abort(abort),
    .bright(bright), .busy(busy), .done(done)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hwclk);
    @(negedge hwclk);
  endtask

  task automatic setch(input int c, input int off, input int on,
                       input int rp);
    off_time[c*CW +: CW] = off;
    on_time[c*CW +: CW]  = on;
    reps[c*RW +: RW]     = rp[RW-1:0];
  endtask

  logic [10:0] vb, vu, vd;
  logic [7:0]  b1, d1, b2, d2;
  logic [5:0]  zu, zd;
  int          errs, dcnt, bor;

  initial begin
    rst_n = 1'b0; on_time = '0; off_time = '0; reps = '0;
    start = '0; start_all = 1'b0; abort = '0;
    tick(); tick();
    chk("rst_bright", 32'(bright), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();

    // off=3 on=2 reps=2 on channel 0
    setch(0, 3, 2, 2);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      vb[i] = bright[0]; vu[i] = busy[0]; vd[i] = done[0];
      tick();
    end
    chk("c0_bright", 32'(vb), 32'(11'b01100011000));
    chk("c0_busy", 32'(vu), 32'(11'b01111111111));
    chk("c0_done", 32'(vd), 32'(11'b10000000000));
    chk("c0_done_1cyc", 32'(done[0]), 32'h0);

    // broadcast start
    setch(0, 0, 0, 1); setch(3, 0, 0, 1);
    setch(1, 0, 4, 1); setch(2, 1, 1, 3);
    start_all = 1'b1; tick(); start_all = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b1[i] = bright[1]; d1[i] = done[1];
      b2[i] = bright[2]; d2[i] = done[2];
      tick();
    end
    chk("c1_bright", 32'(b1), 32'(8'b00001111));
    chk("c1_done", 32'(d1), 32'(8'b00010000));
    chk("c2_bright", 32'(b2), 32'(8'b00101010));
    chk("c2_done", 32'(d2), 32'(8'b01000000));
    chk("all_idle", 32'(busy), 32'h0);

    // infinite repeat then abort on channel 3
    setch(3, 2, 2, 0);
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    errs = 0; dcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bright[3] !== ((i % 4) >= 2)) errs++;
      if (done[3] !== 1'b0) dcnt++;
      if (busy[3] !== 1'b1) errs++;
      tick();
    end
    chk("c3_wave_errs", 32'(errs), 32'h0);
    chk("c3_no_done", 32'(dcnt), 32'h0);
    abort[3] = 1'b1; tick(); abort[3] = 1'b0;
    chk("c3_abort_bright", 32'(bright[3]), 32'h0);
    chk("c3_abort_busy", 32'(busy[3]), 32'h0);
    chk("c3_abort_done", 32'(done[3]), 32'h0);
    tick();
    chk("c3_abort_done2", 32'(done[3]), 32'h0);

    // abort beats start in IDLE
    start[3] = 1'b1; abort[3] = 1'b1; tick();
    start[3] = 1'b0; abort[3] = 1'b0;
    chk("c3_abort_wins", 32'(busy[3]), 32'h0);

    // zero durations, ignored restart, restart on done cycle
    setch(0, 0, 0, 5);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    bor = 0;
    for (int i = 0; i < 6; i++) begin
      zu[i] = busy[0]; zd[i] = done[0];
      if (bright[0] !== 1'b0) bor++;
      if (i == 1) begin
        start[0] = 1'b1; tick(); start[0] = 1'b0;
      end else if (i == 5) begin
        start[0] = 1'b1; tick(); start[0] = 1'b0;
      end else begin
        tick();
      end
    end
    chk("z_busy", 32'(zu), 32'(6'b011111));
    chk("z_done", 32'(zd), 32'(6'b100000));
    chk("z_bright", 32'(bor), 32'h0);
    chk("z_relaunch", 32'(busy[0]), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    chk("z_relaunch_end", 32'(busy[0]), 32'h0);

    // asynchronous reset mid-ON
    setch(0, 1, 10, 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tick(); tick();
    chk("r_in_on", 32'(bright[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_bright", 32'(bright), 32'h0);
    chk("r_busy", 32'(busy), 32'h0);
    chk("r_done", 32'(done), 32'h0);
    @(negedge hwclk);
    rst_n = 1'b1;
    tick(); tick();
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) dcnt++;
      tick();
    end
    chk("r_stay_idle", 32'(dcnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pattern_multi.md
Name: pattern_multi

Overview:
- Parametrised successor to the single-channel LED blink pattern generator: CHANNELS independent blink engines, each producing an off/on waveform repeated a programmable number of times.
- Generalises the counter and repeat widths and adds an infinite-repeat mode, per-channel abort, a broadcast start, and a one-cycle done pulse.
- Sits between the keylock control FSM and the LED pins; the controller programs timings and starts channels, and watches busy/done.

Parameters:
- CHANNELS, 4, number of independent pattern engines (1..16)
- CNT_W, 32, width of on/off time fields in hwclk cycles
- REP_W, 8, width of repeat-count field
- DUTY_W, 4, PWM duty width (used only with PATTERN_PWM_EN)

Ports:
- hwclk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- on_time  in  CHANNELS*CNT_W  per-channel on duration; channel c uses bits [c*CNT_W +: CNT_W]
- off_time  in  CHANNELS*CNT_W  per-channel off duration, same packing
- reps  in  CHANNELS*REP_W  per-channel repeat count; 0 = repeat forever
- start  in  CHANNELS  per-channel start request, sampled each cycle
- start_all  in  1  broadcast start, equivalent to start on every channel
- abort  in  CHANNELS  per-channel abort
- bright  out  CHANNELS  LED drive
- busy  out  CHANNELS  high while the channel is in OFF or ON
- done  out  CHANNELS  one-cycle pulse on completion of the final repetition

Behaviour:
- Reset (rst_n low, asynchronous): all channels go to IDLE; bright=0, busy=0, done=0, all counters 0. Reset mid-pattern discards the pattern; no done pulse is issued.
- Per-channel FSM states: IDLE, OFF, ON. done is a registered pulse, not a state.
- Launch:
  - Effective start = start[c] | start_all, sampled in IDLE only. Start while busy is ignored.
  - Launch on the cycle-t edge: on_time, off_time and reps latch into shadow registers; rep counter and phase counter clear.
  - From cycle t+1 the channel is in OFF (or in ON if latched off_time=0); busy=1.
  - Input changes after launch have no effect.
- OFF: bright=0 for exactly off_time cycles, then the channel enters ON.
- ON: bright=1 for exactly on_time cycles. Then the rep counter increments and the channel enters OFF of the next repetition (skipping OFF if off_time=0).
- Zero durations:
  - on_time=0: ON is skipped.
  - on_time=0 and off_time=0: each repetition takes exactly 1 cycle in OFF with bright=0.
- Completion (reps=N>0):
  - After the N-th repetition ends, the channel returns to IDLE on the same edge the rep counter would reach N.
  - done pulses high for that one following cycle; bright=0 and busy=0 from that cycle.
  - Total busy time = N*(off_time+on_time) cycles, minimum N cycles.
- reps=0: repeat forever; the rep counter does not advance or wrap; done never pulses; only abort or reset stops the channel.
- Abort:
  - abort[c] in OFF or ON: IDLE on the next edge, bright=0, busy=0, no done.
  - abort in IDLE has no effect.
  - abort and start on the same cycle: abort wins and the channel stays or returns to IDLE.
- A start arriving on the done-pulse cycle is accepted (the channel is IDLE); the pattern launches with busy=1 on the next cycle.
- Channels are fully independent; no shared state except the PWM counter.
- Counters compare with CNT_W-bit unsigned arithmetic; no overflow is possible because the phase counter never exceeds max(on_time, off_time)-1.
- All outputs are registered.

Optional Feature:
- PATTERN_PWM_EN defined:
  - Adds input port duty (CHANNELS*DUTY_W) and one free-running DUTY_W-bit counter pwm_cnt, reset to 0 and incrementing every cycle with wrap.
  - In ON, bright = (pwm_cnt < latched duty[c]); duty latches at launch with the other fields.
  - duty=0 gives a dark ON phase; all-ones gives bright for 15 of every 16 cycles when DUTY_W=4.
  - OFF and IDLE behaviour is unchanged.
- PATTERN_PWM_EN undefined: the duty port and pwm_cnt are absent, and bright=1 throughout ON.

Test Plan:
- Reset then start[0] with off=3, on=2, reps=2 -> bright[0] = 0,0,0,1,1,0,0,0,1,1 from t+1; done[0] pulses at t+11; busy[0] high for exactly 10 cycles.
- start_all with channel 1 off=0, on=4, reps=1 and channel 2 off=1, on=1, reps=3 -> channel 1 bright for 4 cycles then done; channel 2 toggles 0,1 three times; done pulses arrive at t+5 and t+7 respectively.
- reps=0, off=2, on=2 on channel 3; run 100 cycles; assert abort[3] -> waveform has period 4 with no done; bright=0 and busy=0 one cycle after abort; no done pulse.
- Start with on=0, off=0, reps=5 -> busy for exactly 5 cycles, bright stays 0, done at t+6. Re-issuing start during busy is ignored; a start on the done-pulse cycle launches again.
- Drive rst_n low mid-ON on channel 0 -> bright, busy and done all 0 immediately (asynchronous, no clock edge needed); stays IDLE after release.
- With PATTERN_PWM_EN, duty=4, DUTY_W=4, on=32 -> bright high for 8 of the 32 ON cycles, in two runs of 4 aligned to pwm_cnt 0..3.
